// File: rtl/prog_loader.sv
// Boot-time program loader: assembles UART bytes into little-endian 32-bit words,
// writes them to instruction memory, and releases the core after a verified checksum.
module prog_loader #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned RST_HOLD       = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Reload,
   input  logic                  i_Rx_Valid,
   input  logic [7:0]            iv_Rx_Byte,
   output logic                  o_Wr_En,
   output logic [ADDR_WIDTH-1:0] ov_Wr_Addr,
   output logic [31:0]           ov_Wr_Data,
   output logic                  o_Core_Rst,
   output logic                  o_Core_Enb,
   output logic                  o_Done,
   output logic                  o_Err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST    = HW'(RST_HOLD - 1);
   localparam logic [16:0]   MAX_WORDS    = 17'(1 << ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CSUM,
      S_HOLD,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                state, state_n;
   logic [15:0]           count, count_n;
   logic [ADDR_WIDTH-1:0] word_idx, word_idx_n;
   logic [1:0]            byte_idx, byte_idx_n;
   logic [23:0]           asm_word, asm_word_n;
   logic [7:0]            csum, csum_n;
   logic [TW-1:0]         timer, timer_n;
   logic [HW-1:0]         hold_cnt, hold_cnt_n;
   logic                  wr_en_n;
   logic [ADDR_WIDTH-1:0] wr_addr_n;
   logic [31:0]           wr_data_n;
   logic                  core_rst_n, core_enb_n, done_n, err_n;

   logic                  in_frame;
   logic                  is_sync;
   logic [15:0]           new_count;
   logic                  last_word;

   assign in_frame  = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
   assign is_sync   = i_Rx_Valid && (iv_Rx_Byte == SYNC_BYTE);
   assign new_count = {iv_Rx_Byte, count[7:0]};
   assign last_word = (16'(word_idx) == (count - 16'd1));

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state      <= S_IDLE;
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
         csum       <= '0;
         timer      <= '0;
         hold_cnt   <= '0;
         o_Wr_En    <= 1'b0;
         ov_Wr_Addr <= '0;
         ov_Wr_Data <= '0;
         o_Core_Rst <= 1'b1;
         o_Core_Enb <= 1'b0;
         o_Done     <= 1'b0;
         o_Err      <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         word_idx   <= word_idx_n;
         byte_idx   <= byte_idx_n;
         asm_word   <= asm_word_n;
         csum       <= csum_n;
         timer      <= timer_n;
         hold_cnt   <= hold_cnt_n;
         o_Wr_En    <= wr_en_n;
         ov_Wr_Addr <= wr_addr_n;
         ov_Wr_Data <= wr_data_n;
         o_Core_Rst <= core_rst_n;
         o_Core_Enb <= core_enb_n;
         o_Done     <= done_n;
         o_Err      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      count_n    = count;
      word_idx_n = word_idx;
      byte_idx_n = byte_idx;
      asm_word_n = asm_word;
      csum_n     = csum;
      timer_n    = timer;
      hold_cnt_n = hold_cnt;
      wr_en_n    = 1'b0;
      wr_addr_n  = ov_Wr_Addr;
      wr_data_n  = ov_Wr_Data;

      if (i_Reload) begin
         state_n    = S_IDLE;
         timer_n    = '0;
         hold_cnt_n = '0;
      end else begin
         // Expiry only fires on an idle cycle, so a byte on the expiry cycle wins.
         if (in_frame) begin
            if (i_Rx_Valid) begin
               timer_n = '0;
            end else if (timer == TIMEOUT_LAST) begin
               timer_n = '0;
               state_n = S_ERROR;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (is_sync) begin
                  state_n = S_CNT_LO;
                  timer_n = '0;
               end
            end
            S_CNT_LO: begin
               if (i_Rx_Valid) begin
                  count_n[7:0] = iv_Rx_Byte;
                  state_n      = S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (i_Rx_Valid) begin
                  count_n = new_count;
                  if ((new_count == 16'd0) || ({1'b0, new_count} > MAX_WORDS)) begin
                     state_n = S_ERROR;
                  end else begin
                     state_n    = S_DATA;
                     word_idx_n = '0;
                     byte_idx_n = '0;
                     csum_n     = '0;
                  end
               end
            end
            S_DATA: begin
               if (i_Rx_Valid) begin
                  csum_n = csum ^ iv_Rx_Byte;
                  case (byte_idx)
                     2'd0: begin
                        asm_word_n[7:0] = iv_Rx_Byte;
                        byte_idx_n      = 2'd1;
                     end
                     2'd1: begin
                        asm_word_n[15:8] = iv_Rx_Byte;
                        byte_idx_n       = 2'd2;
                     end
                     2'd2: begin
                        asm_word_n[23:16] = iv_Rx_Byte;
                        byte_idx_n        = 2'd3;
                     end
                     default: begin
                        wr_en_n    = 1'b1;
                        wr_addr_n  = word_idx;
                        wr_data_n  = {iv_Rx_Byte, asm_word};
                        byte_idx_n = 2'd0;
                        // Index stops at the last word so a full image never wraps.
                        if (last_word) begin
                           state_n = S_CSUM;
                        end else begin
                           word_idx_n = word_idx + 1'b1;
                        end
                     end
                  endcase
               end
            end
            S_CSUM: begin
               if (i_Rx_Valid) begin
                  if (iv_Rx_Byte == csum) begin
                     state_n    = S_HOLD;
                     hold_cnt_n = '0;
                  end else begin
                     state_n = S_ERROR;
                  end
               end
            end
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_n = S_RUN;
               end else begin
                  hold_cnt_n = hold_cnt + 1'b1;
               end
            end
            S_RUN: begin
               state_n = S_RUN;
            end
            S_ERROR: begin
               if (is_sync) begin
                  state_n = S_CNT_LO;
                  timer_n = '0;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end

      // Core controls are registered from the next state so they switch cleanly.
      core_rst_n = (state_n != S_RUN);
      core_enb_n = (state_n == S_RUN);
      done_n     = (state_n == S_RUN);
      err_n      = (state_n == S_ERROR);
   end

endmodule
